// File: rtl/cpu_clk_dbg.sv
// CPU clock generator (halt / free-run / fast / debounced single-step) with reset stretch,
// CPU cycle counter and LED probe-byte mux. Every output is a register on iClk.
module cpu_clk_dbg #(
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 10_000_000,
  parameter int DEB_CYCLES  = 20,
  parameter int RST_HOLD    = 16,
  parameter int SEL_W       = 2
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [1:0]               iMode,
  input  logic [CNT_W-1:0]         iHalfPeriod,
  input  logic                     iStep,
  input  logic [(2**SEL_W)*32-1:0] iProbe,
  input  logic [SEL_W-1:0]         iProbeSel,
  input  logic [1:0]               iByteSel,
  output logic                     oCpuClk,
  output logic                     oCpuRst_n,
  output logic [31:0]              oCycles,
  output logic [7:0]               oLED
);

  localparam int RW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  logic             cpu_clk_q,   cpu_clk_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic [RW-1:0]    rst_cnt_q,   rst_cnt_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      cycles_q,    cycles_d;
  logic [7:0]       led_q,       led_d;
  logic             sync1_q,     sync2_q;
  logic             deb_q,       deb_d;
  logic [DW-1:0]    deb_cnt_q,   deb_cnt_d;
  logic             deb_prev_q;
  logic [1:0]       mode_prev_q;

  logic [CNT_W-1:0] hp;
  logic [CNT_W-1:0] hp_m1;
  logic             div_wrap;
  logic             step_rise;
  logic             mode_chg;
  logic [SEL_W+4:0] led_idx;

  always_comb begin
    hp        = (iHalfPeriod == '0) ? CNT_W'(DIV_DEFAULT) : iHalfPeriod;
    hp_m1     = hp - CNT_W'(1);
    div_wrap  = (cnt_q >= hp_m1);
    step_rise = deb_q & ~deb_prev_q;
    mode_chg  = (iMode != mode_prev_q);
    led_idx   = {iProbeSel, iByteSel, 3'b000};
  end

  // Reset stretch: count edges since release, then hold the CPU reset released.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    cpu_rst_n_d = cpu_rst_n_q;
    if (!cpu_rst_n_q) begin
      if (rst_cnt_q == RW'(RST_HOLD)) cpu_rst_n_d = 1'b1;
      else                            rst_cnt_d   = rst_cnt_q + RW'(1);
    end
  end

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) deb_d     = sync2_q;
      else                                  deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  // The divider counter doubles as the step-pulse length counter.
  always_comb begin
    cpu_clk_d = cpu_clk_q;
    cnt_d     = cnt_q;
    if (!cpu_rst_n_q || mode_chg) begin
      cpu_clk_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (mode_e'(iMode))
        MODE_HALT: begin
          cpu_clk_d = 1'b0;
          cnt_d     = '0;
        end
        MODE_RUN: begin
          if (div_wrap) begin
            cnt_d     = '0;
            cpu_clk_d = ~cpu_clk_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_STEP: begin
          if (cpu_clk_q) begin
            if (div_wrap) begin
              cnt_d     = '0;
              cpu_clk_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
            if (step_rise) cpu_clk_d = 1'b1;
          end
        end
        MODE_FAST: begin
          cpu_clk_d = ~cpu_clk_q;
          cnt_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    cycles_d = cycles_q + {31'd0, cpu_clk_d & ~cpu_clk_q};
    led_d    = iProbe[led_idx +: 8];
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cpu_clk_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
      led_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      deb_prev_q  <= 1'b0;
      mode_prev_q <= iMode;
    end else begin
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      led_q       <= led_d;
      sync1_q     <= iStep;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_prev_q  <= deb_q;
      mode_prev_q <= iMode;
    end
  end

  assign oCpuClk   = cpu_clk_q;
  assign oCpuRst_n = cpu_rst_n_q;
  assign oCycles   = cycles_q;
  assign oLED      = led_q;

endmodule

// File: doc/cpu_clk_dbg.md
# cpu_clk_dbg

Board-level CPU clock and debug controller between the FPGA pins and the CPU core. Divides the board clock into a CPU clock with runtime-selectable halt, free-run, fast and debounced single-step modes. Stretches the CPU reset, counts CPU cycles, and drives the 8 LEDs with one byte picked from several 32-bit probe words.

## Interface
Parameters:
- CNT_W, 32: width of the divider counter and of `iHalfPeriod`.
- DIV_DEFAULT, 10_000_000: half period in `iClk` cycles, used when `iHalfPeriod` is 0.
- DEB_CYCLES, 20: number of `iClk` cycles the synchronised step button must stay stable before it is accepted.
- RST_HOLD, 16: number of `iClk` cycles `oCpuRst_n` stays low after `iRst_n` releases.
- SEL_W, 2: probe select width. NPROBE = 2**SEL_W.

Ports:
- iClk  in  1  board clock; the only clock.
- iRst_n  in  1  reset, synchronous, active-low.
- iMode  in  2  00 halt, 01 free-run, 10 single-step, 11 fast.
- iHalfPeriod  in  CNT_W  half period in free-run; 0 selects DIV_DEFAULT.
- iStep  in  1  raw, asynchronous step button, active-high.
- iProbe  in  NPROBE*32  probe words; channel k is bits [32k+31:32k].
- iProbeSel  in  SEL_W  selects the probe channel.
- iByteSel  in  2  selects the byte within the channel.
- oCpuClk  out  1  registered CPU clock.
- oCpuRst_n  out  1  stretched CPU reset, active-low.
- oCycles  out  32  count of `oCpuClk` rising edges.
- oLED  out  8  selected probe byte.

## Operation
- Reset (`iRst_n`=0 at a clock edge): oCpuClk=0, oCpuRst_n=0, oCycles=0, oLED=0. Divider, stretch counter, debouncer and synchroniser all cleared. The button is treated as released. Reset applies mid-operation the same way.
- Stretch: after reset releases, oCpuRst_n stays 0 for RST_HOLD cycles, then goes 1. During the stretch oCpuClk is held 0 and the divider is held at 0.
- Effective half period: hp = (iHalfPeriod==0) ? DIV_DEFAULT : iHalfPeriod. hp is sampled every cycle, with no latching.
- Free-run: the divider increments each cycle. When cnt >= hp-1, cnt becomes 0 and oCpuClk toggles. Because the compare is `>=`, shrinking hp below cnt wraps on the next cycle. The period is 2*hp.
- Fast: oCpuClk toggles every cycle, giving a period of 2. The divider is held at 0.
- Halt: oCpuClk is driven 0 and the divider held at 0.
- Single-step:
  - iStep passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
  - A debounced 0->1 edge, while oCpuClk=0, raises oCpuClk for exactly hp cycles, then drops it.
  - Edges seen while oCpuClk=1 are ignored. A held button gives exactly one step.
- Mode change (iMode differs from the previous cycle's value):
  - Next cycle: oCpuClk=0, cnt=0, any in-progress step pulse cancelled.
  - The new mode runs from the following cycle.
- oCycles increments on every 0->1 transition of registered oCpuClk and wraps at 2^32.
- oLED is a register loaded each cycle with iProbe[32*iProbeSel + 8*iByteSel +: 8].

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- oCpuRst_n rises exactly RST_HOLD cycles after the first edge with iRst_n=1.
- First free-run rising edge: oCpuClk goes high hp cycles after the first post-stretch cycle.
- oCycles updates in the same cycle oCpuClk goes high.
- Step latency from a clean press: 2 cycles (synchroniser) + DEB_CYCLES + 1 cycle (edge detect) until oCpuClk goes high.
- oLED latency: 1 cycle from iProbe, iProbeSel or iByteSel.
- Precedence: reset > stretch > mode change > mode behaviour.

## Test plan
- Reset and stretch, RST_HOLD=4: hold iRst_n=0 for 5 cycles, then release in free-run with hp=3.
  - All outputs 0 during reset.
  - oCpuRst_n rises 4 cycles after release.
  - oCpuClk rises 3 cycles after that, and oCycles=1.
- Free-run, iHalfPeriod=3: oCpuClk toggles every 3 cycles. oCycles=10 after 60 cycles from the first edge. Setting iHalfPeriod=0 with DIV_DEFAULT=10 gives toggles every 10 cycles.
- Divider boundary: at cnt=7 with hp=10, change iHalfPeriod to 2. oCpuClk toggles on the next cycle and then every 2 cycles.
- Single-step, DEB_CYCLES=4, hp=5: toggle iStep every cycle for 6 cycles, then hold it at 1 for 100 cycles.
  - Exactly one high pulse of 5 cycles.
  - oCycles increments by 1.
  - A second clean press gives a second pulse.
- Halt and mode change: switch free-run to halt while oCpuClk=1. oCpuClk is 0 on the next cycle and stays 0 for 50 cycles, with oCycles frozen. Switching to fast then toggles every cycle.
- Probe mux, SEL_W=2: iProbe channel 2 = 0xDEADBEEF, iProbeSel=2.
  - iByteSel=1: oLED=0xBE one cycle later.
  - iByteSel=3: oLED=0xDE.
  - Assert reset mid-run: oLED=0 on the next cycle.
